// File: rtl/psram_pkg.sv
// Shared psram constants and the arbiter state encoding.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 24;
  localparam int PSRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/psram_rr_pick.sv
// Round-robin pick among the low-priority ports 1..NUM_REQ-1.
// Searches from ptr upward, then wraps to port 1. Port 0 is never picked here.
module psram_rr_pick
  import psram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  logic found;
  int   ptr_i;

  // First requester at or after ptr, wrapping back to port 1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    any   = 1'b0;
    ptr_i = int'(ptr);
    for (int k = 1; k < NUM_REQ; k++) begin
      any = any | req[k];
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!found && req[k] && (k >= ptr_i)) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!found && req[k] && (k < ptr_i)) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Arbiter sharing one psram controller between NUM_REQ requesters.
// Port 0 (video line fetch) has fixed top priority, bounded by a starvation
// guard; ports 1..NUM_REQ-1 are served round-robin.
//
// Handshake: a requester raises i_req[k] with its we/addr/din and holds it
// until it sees o_done[k] or (o_err while o_gnt[k]). Command fields are
// latched at grant, so later changes are ignored. Dropping i_req after the
// grant does not cancel the access. Toward the controller, o_mem_stb is a
// one-cycle strobe issued only while i_mem_busy is low; completion is the
// first i_mem_done seen in WAIT, or a timeout after TIMEOUT WAIT cycles.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = PSRAM_ADDR_W,
  parameter int DATA_W       = PSRAM_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_din,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_dout,
  output logic                      o_err,
  output logic                      o_mem_stb,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_din,
  input  logic                      i_mem_busy,
  input  logic                      i_mem_done,
  input  logic [DATA_W-1:0]         i_mem_dout,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  arb_state_t          state, state_next;
  logic [NUM_REQ-1:0]  gnt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [DATA_W-1:0]   dout_q;
  logic                err_flag;
  logic [PTR_W-1:0]    rr_ptr;
  logic [SC_W-1:0]     starve_cnt;
  logic [TO_W-1:0]     to_cnt;

  logic [NUM_REQ-1:0]  lo_win;
  logic                lo_pend;
  logic                pick0;
  logic [NUM_REQ-1:0]  win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_din;
  logic [PTR_W-1:0]    rr_next;
  logic                timed_out;

  psram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req (i_req),
    .ptr (rr_ptr),
    .win (lo_win),
    .any (lo_pend)
  );

  // Winner selection, command mux and the round-robin pointer advance.
  always_comb begin
    pick0    = i_req[0] && ((starve_cnt < SC_W'(STARVE_LIMIT)) || !lo_pend);
    win      = pick0 ? {{(NUM_REQ-1){1'b0}}, 1'b1} : lo_win;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    rr_next  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        sel_we   = i_we[k];
        sel_addr = i_addr[k*ADDR_W +: ADDR_W];
        sel_din  = i_din[k*DATA_W +: DATA_W];
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (lo_win[k]) begin
        rr_next = (k == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(k + 1);
      end
    end
  end

  assign timed_out = ((to_cnt + TO_W'(1)) == TO_W'(TIMEOUT));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a done in the timeout cycle still counts as success.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (|i_req)                   state_next = ISSUE;
      ISSUE: if (!i_mem_busy)              state_next = WAIT;
      WAIT:  if (i_mem_done || timed_out)  state_next = DONE;
      DONE:                                state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Grant, latched command, starvation/round-robin bookkeeping and result capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      dout_q     <= '0;
      err_flag   <= 1'b0;
      rr_ptr     <= PTR_W'(1);
      starve_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      if (!lo_pend) starve_cnt <= '0;
      case (state)
        IDLE: begin
          if (|i_req) begin
            gnt      <= win;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            err_flag <= 1'b0;
            to_cnt   <= '0;
            if (pick0) begin
              if (lo_pend && (starve_cnt != SC_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SC_W'(1);
            end else begin
              starve_cnt <= '0;
              rr_ptr     <= rr_next;
            end
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (i_mem_done) begin
            if (!mem_we) dout_q <= i_mem_dout;
          end else if (timed_out) begin
            err_flag <= 1'b1;
          end
        end
        DONE: begin
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_gnt      = gnt;
  assign o_done     = ((state == DONE) && !err_flag) ? gnt : '0;
  assign o_err      = (state == DONE) && err_flag;
  assign o_dout     = dout_q;
  assign o_mem_stb  = (state == ISSUE) && !i_mem_busy;
  assign o_mem_we   = mem_we;
  assign o_mem_addr = mem_addr;
  assign o_mem_din  = mem_din;
  assign dbg_state  = state;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter with a behavioural psram controller.
module tb_psram_arbiter;
  import psram_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 255;
  localparam int EW  = 1 + N + DW;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      o_gnt;
  logic [N-1:0]      o_done;
  logic [DW-1:0]     o_dout;
  logic              o_err;
  logic              o_mem_stb;
  logic              o_mem_we;
  logic [AW-1:0]     o_mem_addr;
  logic [DW-1:0]     o_mem_din;
  logic              busy;
  logic              mem_done;
  logic [DW-1:0]     mem_dout;
  logic [1:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  exp_gnt_q[$];

  // controller model state
  int            lat       = 5;
  int            cnt       = 0;
  logic          hang      = 1'b0;
  logic [DW-1:0] resp      = '0;
  int            stb_count = 0;
  int            stb_cyc   = 0;
  int            done_cyc  = -10;
  int            err_count = 0;
  int            cyc       = 0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  logic [N-1:0]  keep      = '0;
  logic [N-1:0]  prev_gnt  = '0;
  logic [DW-1:0] last_dout = '0;
  int            s0;
  int            e0;
  int            n;

  psram_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .TIMEOUT(TMO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_din      (din),
    .o_gnt      (o_gnt),
    .o_done     (o_done),
    .o_dout     (o_dout),
    .o_err      (o_err),
    .o_mem_stb  (o_mem_stb),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_din  (o_mem_din),
    .i_mem_busy (busy),
    .i_mem_done (mem_done),
    .i_mem_dout (mem_dout),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // controller model: done pulse lat cycles after each accepted strobe
  initial begin
    mem_done = 1'b0;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_done = 1'b1;
            mem_dout = resp;
            done_cyc = cyc;
          end
        end
        if (o_mem_stb) begin
          stb_count++;
          stb_cyc = cyc;
          m_we    = o_mem_we;
          m_addr  = o_mem_addr;
          m_din   = o_mem_din;
          if (!hang) cnt = lat;
        end
      end
    end
  end

  // scoreboard / protocol monitor
  initial forever begin
    @(posedge clk);
    #3;
    if (!rst) begin
      check("gnt_onehot", $countones(o_gnt) <= 1, 1);
      check("stb_vs_busy", o_mem_stb & busy, 0);
      if (o_gnt != '0 && o_gnt != prev_gnt) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", o_gnt, 0);
        else                       check("gnt_order", o_gnt, exp_gnt_q.pop_front());
      end
      if (o_done != '0 || o_err) begin
        if (exp_q.size() == 0) check("completion_unexpected", {o_err, o_done, o_dout}, 0);
        else                   check("completion", {o_err, o_done, o_dout}, exp_q.pop_front());
        if (o_done != '0) check("done_latency", cyc - done_cyc, 1);
        if (o_err) begin
          err_count++;
          check("err_latency", cyc - stb_cyc, TMO + 1);
        end
      end
    end
    prev_gnt = o_gnt;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (!keep[k] && (o_done[k] || (o_err && o_gnt[k]))) req[k] = 1'b0;
    end
  endtask

  task automatic set_port(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k]            = w;
    addr[k*AW +: AW] = a;
    din[k*DW +: DW]  = d;
  endtask

  task automatic wait_done(input int k, input string tag);
    int t;
    t = 0;
    while (!o_done[k] && t < 600) begin
      tick();
      t++;
    end
    check({tag, "_done_seen"}, o_done[k], 1);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    keep = '0;
    busy = 1'b0;
    repeat (3) tick();
    rst       = 1'b0;
    last_dout = '0;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    we   = '0;
    addr = '0;
    din  = '0;
    busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {o_gnt, o_done, o_err, o_mem_stb, o_mem_we}, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_din", o_mem_din, 0);
    check("rst_dout", o_dout, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();

    // single read on port 1
    lat  = 5;
    resp = 16'h8765;
    set_port(1, 1'b0, 24'h000123, 16'h0);
    s0 = stb_count;
    exp_gnt_q.push_back(3'b010);
    exp_q.push_back({1'b0, 3'b010, 16'h8765});
    req[1] = 1'b1;
    tick();
    check("t1_gnt_cycle1", o_gnt, 3'b010);
    check("t1_cmd_addr", o_mem_addr, 24'h000123);
    wait_done(1, "t1");
    check("t1_dout", o_dout, 16'h8765);
    check("t1_stb_count", stb_count - s0, 1);
    last_dout = 16'h8765;
    tick();
    check("t1_gnt_clear", o_gnt, 0);

    // contention: starvation guard then round-robin
    do_reset();
    lat  = 3;
    resp = 16'h4321;
    for (int k = 0; k < N; k++) set_port(k, 1'b0, AW'(24'h000100 + k), 16'h0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_gnt_q.push_back(3'b001);
        exp_q.push_back({1'b0, 3'b001, 16'h4321});
      end
      exp_gnt_q.push_back(r == 0 ? 3'b010 : 3'b100);
      exp_q.push_back({1'b0, (r == 0 ? 3'b010 : 3'b100), 16'h4321});
    end
    keep[0] = 1'b1;
    req     = 3'b111;
    n = 0;
    while (!o_done[2] && n < 400) begin
      tick();
      n++;
    end
    check("t2_port2_done", o_done[2], 1);
    req[0]  = 1'b0;
    keep[0] = 1'b0;
    repeat (3) tick();
    check("t2_gnt_seq_consumed", exp_gnt_q.size(), 0);
    last_dout = 16'h4321;

    // busy hold-off on a port 2 write
    busy = 1'b1;
    set_port(2, 1'b1, 24'h00FFFE, 16'hBEEF);
    exp_gnt_q.push_back(3'b100);
    exp_q.push_back({1'b0, 3'b100, last_dout});
    s0 = stb_count;
    req[2] = 1'b1;
    repeat (10) tick();
    check("t3_state_issue", dbg_state, ISSUE);
    check("t3_no_stb", stb_count - s0, 0);
    check("t3_gnt", o_gnt, 3'b100);
    busy = 1'b0;
    wait_done(2, "t3");
    check("t3_one_stb", stb_count - s0, 1);
    check("t3_mem_we", m_we, 1);
    check("t3_mem_addr", m_addr, 24'h00FFFE);
    check("t3_mem_din", m_din, 16'hBEEF);
    check("t3_dout_held", o_dout, last_dout);
    tick();

    // timeout on port 1, port 2 pending behind it
    hang = 1'b1;
    lat  = 3;
    resp = 16'h0F0F;
    set_port(1, 1'b0, 24'h000456, 16'h0);
    set_port(2, 1'b0, 24'h000789, 16'h0);
    exp_gnt_q.push_back(3'b010);
    exp_gnt_q.push_back(3'b100);
    exp_q.push_back({1'b1, 3'b000, last_dout});
    exp_q.push_back({1'b0, 3'b100, 16'h0F0F});
    e0 = err_count;
    req = 3'b110;
    n = 0;
    while (!o_err && n < 400) begin
      tick();
      n++;
    end
    check("t4_err_seen", o_err, 1);
    check("t4_no_done_on_err", o_done, 0);
    hang = 1'b0;
    wait_done(2, "t4");
    check("t4_err_once", err_count - e0, 1);
    last_dout = 16'h0F0F;
    tick();

    // reset while in WAIT
    lat  = 20;
    resp = 16'h1111;
    set_port(1, 1'b0, 24'h000AAA, 16'h0);
    exp_gnt_q.push_back(3'b010);
    req[1] = 1'b1;
    n = 0;
    while (dbg_state != WAIT && n < 20) begin
      tick();
      n++;
    end
    check("t5_reached_wait", dbg_state, WAIT);
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_ctrl", {o_gnt, o_done, o_err, o_mem_stb}, 0);
    check("t5_async_cmd", {o_mem_we, o_mem_addr, o_mem_din, o_dout}, 0);
    check("t5_async_state", dbg_state, IDLE);
    req = '0;
    repeat (2) tick();
    rst       = 1'b0;
    last_dout = '0;
    tick();
    lat  = 4;
    resp = 16'h2468;
    exp_gnt_q.push_back(3'b010);
    exp_q.push_back({1'b0, 3'b010, 16'h2468});
    req[1] = 1'b1;
    wait_done(1, "t5");
    check("t5_dout", o_dout, 16'h2468);
    last_dout = 16'h2468;
    tick();

    // withdrawal after grant; command changes after grant ignored
    lat  = 4;
    resp = 16'h3C3C;
    set_port(1, 1'b0, 24'h000111, 16'h0);
    set_port(2, 1'b0, 24'h000222, 16'h0);
    exp_gnt_q.push_back(3'b010);
    exp_gnt_q.push_back(3'b100);
    exp_q.push_back({1'b0, 3'b010, 16'h3C3C});
    exp_q.push_back({1'b0, 3'b100, 16'h3C3C});
    req[1] = 1'b1;
    tick();
    check("t6_gnt1", o_gnt, 3'b010);
    set_port(1, 1'b1, 24'hFFFFFF, 16'hDEAD);
    tick();
    req[1] = 1'b0;
    req[2] = 1'b1;
    check("t6_cmd_latched", o_mem_addr, 24'h000111);
    wait_done(1, "t6a");
    check("t6_mem_addr", m_addr, 24'h000111);
    check("t6_mem_we", m_we, 0);
    wait_done(2, "t6b");
    check("t6_dout", o_dout, 16'h3C3C);

    repeat (5) tick();
    check("final_gnt_q_empty", exp_gnt_q.size(), 0);
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
